// File: rtl/logic_32_serial.sv
// logic_32_serial: multi-cycle AND/OR/NOR/INV unit processing SLICE_WIDTH bits per cycle, LSB slice first.
// Optional PARITY output (running XOR of the result) enabled by defining LOGIC_SERIAL_PARITY_EN.
module logic_32_serial #(
    parameter int DATA_WIDTH  = 32,
    parameter int SLICE_WIDTH = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [1:0]            OPRN,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [DATA_WIDTH-1:0] Y,
`ifdef LOGIC_SERIAL_PARITY_EN
    output logic                  PARITY,
`endif
    output logic                  ZERO
);
    localparam int NSLICE = DATA_WIDTH / SLICE_WIDTH;
    localparam int CW = NSLICE > 1 ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    if (SLICE_WIDTH < 1 || SLICE_WIDTH > DATA_WIDTH || (DATA_WIDTH % SLICE_WIDTH) != 0) begin : g_bad_cfg
        $error("SLICE_WIDTH must divide DATA_WIDTH and lie in 1..DATA_WIDTH");
    end

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_e;

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   a_q, a_d, b_q, b_d, acc_q, acc_d, y_q, y_d;
    logic [1:0]              op_q, op_d;
    logic                    zero_q, zero_d;
    logic [SLICE_WIDTH-1:0]  as, bs, rs;

    // Operands shift right each RUN cycle so the active slice is always the low bits;
    // result slices enter the accumulator from the top and settle LSB-first.
    always_comb begin
        as      = a_q[SLICE_WIDTH-1:0];
        bs      = b_q[SLICE_WIDTH-1:0];
        rs      = op_q == 2'b00 ? (as & bs) :
                  op_q == 2'b01 ? (as | bs) :
                  op_q == 2'b10 ? ~(as | bs) : ~as;
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        acc_d   = acc_q;
        y_d     = y_q;
        zero_d  = zero_q;
        if (state_q == IDLE && START) begin
            state_d = RUN;
            cnt_d   = '0;
            a_d     = A;
            b_d     = B;
            op_d    = OPRN;
            acc_d   = '0;
        end else if (state_q == RUN) begin
            a_d   = a_q >> SLICE_WIDTH;
            b_d   = b_q >> SLICE_WIDTH;
            acc_d = DATA_WIDTH'({rs, acc_q} >> SLICE_WIDTH);
            if (cnt_q == LAST) begin
                state_d = FINISH;
                y_d     = acc_d;
                zero_d  = acc_d == '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (state_q == FINISH) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            acc_q   <= '0;
            y_q     <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            zero_q  <= zero_d;
        end
    end

`ifdef LOGIC_SERIAL_PARITY_EN
    logic par_q, par_d, parity_q, parity_d;

    always_comb begin
        par_d    = par_q;
        parity_d = parity_q;
        if (state_q == IDLE && START) begin
            par_d = 1'b0;
        end else if (state_q == RUN) begin
            par_d = par_q ^ (^rs);
            if (cnt_q == LAST) parity_d = par_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            par_q    <= 1'b0;
            parity_q <= 1'b0;
        end else begin
            par_q    <= par_d;
            parity_q <= parity_d;
        end
    end

    assign PARITY = parity_q;
`endif

    assign BUSY = state_q == RUN;
    assign DONE = state_q == FINISH;
    assign Y    = y_q;
    assign ZERO = zero_q;
endmodule

// File: tb/tb_logic_32_serial.sv
// tb_logic_32_serial: scoreboard bench for logic_32_serial (default slicing plus a single-slice instance).
module tb_logic_32_serial;
    logic        CLK = 1'b0, RST = 1'b0, START = 1'b0, START1 = 1'b0;
    logic [1:0]  OPRN = 2'b00;
    logic [31:0] A = '0, B = '0;
    logic        BUSY, DONE, ZERO, BUSY1, DONE1, ZERO1;
    logic [31:0] Y, Y1;
`ifdef LOGIC_SERIAL_PARITY_EN
    logic        PARITY, PARITY1;
`endif

    typedef struct {logic [31:0] y; logic zero;} exp_t;
    exp_t sb[$];
    int n_checks = 0, n_fail = 0, done_cnt = 0;

    logic_32_serial u_dut (
        .CLK(CLK), .RST(RST), .START(START), .OPRN(OPRN), .A(A), .B(B),
        .BUSY(BUSY), .DONE(DONE), .Y(Y),
`ifdef LOGIC_SERIAL_PARITY_EN
        .PARITY(PARITY),
`endif
        .ZERO(ZERO)
    );

    logic_32_serial #(.SLICE_WIDTH(32)) u_dut1 (
        .CLK(CLK), .RST(RST), .START(START1), .OPRN(OPRN), .A(A), .B(B),
        .BUSY(BUSY1), .DONE(DONE1), .Y(Y1),
`ifdef LOGIC_SERIAL_PARITY_EN
        .PARITY(PARITY1),
`endif
        .ZERO(ZERO1)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return ~(a | b);
            default: return ~a;
        endcase
    endfunction

    always @(negedge CLK) begin
        exp_t e;
        if (DONE) begin
            done_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("y", Y, e.y);
                check("zero", {31'd0, ZERO}, {31'd0, e.zero});
            end
        end
    end

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op, input bit push);
        logic [31:0] e;
        e = model(a, b, op);
        @(posedge CLK); #1;
        A = a; B = b; OPRN = op; START = 1'b1;
        if (push) sb.push_back('{y: e, zero: (e == 32'd0)});
        @(posedge CLK); #1;
        START = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int lat);
        int n = 0, busy = 0;
        while (n < 60) begin
            @(negedge CLK);
            n++;
            if (DONE) break;
            if (BUSY) busy++;
        end
        check({tag, "_lat"}, n, lat + 1);
        check({tag, "_busy_cycles"}, busy, lat);
        check({tag, "_busy_at_done"}, {31'd0, BUSY}, 32'd0);
        @(negedge CLK);
        check({tag, "_pulse"}, {31'd0, DONE}, 32'd0);
    endtask

    initial begin
        int n, d0;
        START = 1'b1; A = 32'hDEADBEEF; B = 32'h12345678; OPRN = 2'b01;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_busy", {31'd0, BUSY}, 32'd0);
        check("rst_done", {31'd0, DONE}, 32'd0);
        check("rst_y", Y, 32'd0);
        check("rst_zero", {31'd0, ZERO}, 32'd0);
        check("rst_busy1", {31'd0, BUSY1}, 32'd0);
        START = 1'b0; RST = 1'b1;
        @(negedge CLK);
        check("idle_after_rst", {31'd0, BUSY}, 32'd0);

        start_op(32'hF0F01234, 32'hFF00FF00, 2'b00, 1'b1);
        wait_done("and", 8);
        start_op(32'h0, 32'h0, 2'b01, 1'b1);
        wait_done("or0", 8);
        start_op(32'h0, 32'h0, 2'b10, 1'b1);
        wait_done("nor0", 8);

        d0 = done_cnt;
        start_op(32'h0000FFFF, 32'h12345678, 2'b11, 1'b1);
        @(posedge CLK); #1;
        A = 32'hFFFFFFFF; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        n = 0;
        while (!DONE && n < 40) begin
            @(negedge CLK);
            n++;
        end
        check("inv_done_seen", {31'd0, DONE}, 32'd1);
        repeat (12) @(negedge CLK);
        check("inv_done_once", done_cnt - d0, 32'd1);
        check("inv_idle", {31'd0, BUSY}, 32'd0);

        d0 = done_cnt;
        start_op(32'hFFFFFFFF, 32'h0F0F0F0F, 2'b00, 1'b0);
        repeat (2) begin @(posedge CLK); #1; end
        RST = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b1;
        @(negedge CLK);
        check("abort_busy", {31'd0, BUSY}, 32'd0);
        check("abort_done", {31'd0, DONE}, 32'd0);
        check("abort_y", Y, 32'd0);
        check("abort_zero", {31'd0, ZERO}, 32'd0);
        repeat (10) @(negedge CLK);
        check("abort_no_done", done_cnt - d0, 32'd0);

        start_op(32'hAAAAAAAA, 32'hAAAAAAAA, 2'b00, 1'b1);
        wait_done("restart", 8);

        for (int i = 0; i < 4; i++) begin
            start_op($urandom, $urandom, 2'($urandom_range(0, 3)), 1'b1);
            wait_done("rand", 8);
        end

        @(posedge CLK); #1;
        A = 32'h00000007; B = 32'h0; OPRN = 2'b01; START1 = 1'b1;
        @(posedge CLK); #1;
        START1 = 1'b0;
        n = 0;
        while (!DONE1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check("sw32_lat", n, 32'd2);
        check("sw32_y", Y1, 32'h00000007);
        check("sw32_zero", {31'd0, ZERO1}, 32'd0);
`ifdef LOGIC_SERIAL_PARITY_EN
        check("sw32_parity", {31'd0, PARITY1}, 32'd1);
`endif
        @(negedge CLK);
        check("sw32_pulse", {31'd0, DONE1}, 32'd0);

        repeat (2) @(negedge CLK);
        check("sb_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/logic_32_serial.md
Name: logic_32_serial

Overview:
- Multi-cycle 32-bit logic unit: sequential counterpart to the single-cycle 32-bit gate arrays (AND/OR/NOR/INV).
- Captures operands on a start handshake and processes SLICE_WIDTH bits per cycle, LSB slice first.
- Presents the full result with a one-cycle done pulse.
- Sits beside the ALU for area-reduced builds. The datapath instantiates it when a parallel logic array is not wanted.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- SLICE_WIDTH, 4, bits processed per cycle.
  - Must divide DATA_WIDTH exactly.
  - Legal range 1..DATA_WIDTH.
  - NSLICE = DATA_WIDTH/SLICE_WIDTH (8 at defaults).

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- RST  input  1  reset, synchronous, active-low.
- START  input  1  request; sampled only in IDLE.
- OPRN  input  2  operation: 00 AND, 01 OR, 10 NOR, 11 INV (~A, B ignored).
- A  input  DATA_WIDTH  operand A.
- B  input  DATA_WIDTH  operand B.
- BUSY  output  1  high while slices are being processed.
- DONE  output  1  one-cycle pulse; Y/ZERO updated.
- Y  output  DATA_WIDTH  registered result, held until next completion.
- ZERO  output  1  registered: Y == 0.

Behaviour:
- Reset:
  - RST==0 at a rising edge forces state IDLE, slice counter 0, BUSY=0, DONE=0, Y=0, ZERO=0.
  - Operand/op capture registers clear to 0.
  - Reset has priority over every other event, including mid-RUN. An aborted operation never produces DONE, and Y stays 0.
- States: IDLE, RUN, FINISH. Encoding is free.
- IDLE:
  - BUSY=0, DONE=0.
  - START==1 at edge t0: capture A, B, OPRN into internal regs, counter=0, go RUN.
  - START==0: stay IDLE.
- RUN:
  - BUSY=1.
  - Each cycle computes result slice [cnt*SLICE_WIDTH +: SLICE_WIDTH] from the captured operands into an internal accumulator, then cnt increments.
  - After slice NSLICE-1 is computed, go FINISH.
  - RUN lasts exactly NSLICE cycles: edges t0+1 .. t0+NSLICE.
- FINISH:
  - Entered at edge t0+NSLICE. At that same edge Y<=accumulator, ZERO<=(accumulator==0), DONE<=1, BUSY<=0.
  - Next edge returns to IDLE and DONE<=0.
- Latency: START sampled at t0 -> DONE high and Y valid during cycle after edge t0+NSLICE.
  - At defaults, 8 cycles.
  - SLICE_WIDTH==DATA_WIDTH gives 1 cycle.
- Throughput: next START accepted earliest at edge t0+NSLICE+1.
- START while BUSY or during FINISH is ignored (not queued).
- Changes on A/B/OPRN after capture do not affect the in-flight result.
- Y and ZERO are not disturbed during RUN. They hold the previous completed result.
- Counter width is clog2(NSLICE), minimum 1 bit. The counter never wraps past NSLICE-1.

Optional Feature:
- LOGIC_SERIAL_PARITY_EN:
  - Defined: adds output PARITY (1 bit), registered alongside Y at FINISH as XOR-reduction of the result.
  - Computed incrementally per slice (running XOR accumulator), not from Y.
  - Cleared to 0 by reset and at capture.
- Undefined: PARITY port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset: hold RST=0 for 2 edges with START=1 -> BUSY=0, DONE=0, Y=0x00000000, ZERO=0; no capture.
- AND: A=0xF0F01234, B=0xFF00FF00, OPRN=00, START pulse at t0 -> BUSY=1 for 8 cycles; DONE=1 for exactly one cycle after t0+8; Y=0xF0001200, ZERO=0.
- OR then NOR on zeros:
  - A=0, B=0, OPRN=01 -> Y=0x00000000, ZERO=1.
  - Then OPRN=10 -> Y=0xFFFFFFFF, ZERO=0.
- INV and capture isolation:
  - A=0x0000FFFF, B=0x12345678, OPRN=11.
  - At RUN cycle 2, change A to 0xFFFFFFFF and pulse START -> ignored; Y=0xFFFF0000 at DONE.
  - Exactly one DONE pulse.
- Reset mid-operation:
  - Start AND, assert RST=0 at RUN cycle 3 -> next cycle IDLE, BUSY=0, Y=0, no DONE.
  - Restart with A=B=0xAAAAAAAA, OPRN=00 -> Y=0xAAAAAAAA after 8 cycles.
- Parameter/feature: SLICE_WIDTH=32 with LOGIC_SERIAL_PARITY_EN defined, OPRN=01, A=0x00000007, B=0 -> DONE one cycle after START; Y=0x00000007, PARITY=1.
